// File: rtl/if1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : if1_pkg
// Description : Shared constants and packet type for the IF1 fetch buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package if1_pkg;

    localparam logic [31:0] INST_NOP          = 32'h0340_0000;
    localparam int          c_excp_w_def      = 7;
    // Packet storage is sized for the widest configuration; narrower
    // instances leave the upper bits at zero.
    localparam int          c_max_fetch_width = 8;
    localparam int          c_max_excp_w      = 16;

    typedef struct packed {
        logic [31:0]                    pc;
        logic [32*c_max_fetch_width-1:0] inst;
        logic [c_max_fetch_width-1:0]   slot_valid;
        logic [c_max_excp_w-1:0]        exception;
        logic [1:0]                     excp_flag;
        logic [31:0]                    badv;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } buf_state_t;

endpackage
`default_nettype wire

// File: rtl/if1_align.sv
`default_nettype none
// ============================================================================
// Module      : if1_align
// Description : Combinational PC-offset slot mask, NOP fill and exception
//               one-hot for one ICache line.
// Revision    : 1.0 - initial release
// ============================================================================
module if1_align
    import if1_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int EXCP_W      = c_excp_w_def
) (
    input  logic [31:0]              i_pc,
    input  logic [32*FETCH_WIDTH-1:0] i_rdata,
    input  logic [EXCP_W-1:0]        i_exception,
    input  logic [1:0]               i_excp_flag,
    output logic [32*FETCH_WIDTH-1:0] o_inst,
    output logic [FETCH_WIDTH-1:0]   o_slot_valid
);

    localparam int c_off_w = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1;

    logic [c_off_w-1:0] w_off;
    logic               w_excp;
    logic               w_unused_pc;

    generate
        if (FETCH_WIDTH > 1) begin : g_off_multi
            assign w_off = i_pc[2 +: c_off_w];
        end else begin : g_off_single
            assign w_off = '0;
        end
    endgenerate

    assign w_excp      = (i_exception != '0) || (i_excp_flag != 2'b00);
    assign w_unused_pc = ^i_pc;

    // A faulting fetch carries no usable instructions; only the slot the PC
    // points at stays valid so the exception has a single owner.
    always_comb begin
        o_inst       = '0;
        o_slot_valid = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (w_excp) begin
                o_slot_valid[i]    = (i == int'(w_off));
                o_inst[32*i +: 32] = INST_NOP;
            end else begin
                o_slot_valid[i]    = (i >= int'(w_off));
                o_inst[32*i +: 32] = (i >= int'(w_off)) ? i_rdata[32*i +: 32] : INST_NOP;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/if1_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : if1_fetch_buf
// Description : IF1 fetch buffer; aligns ICache lines and holds them in a
//               two-entry registered skid buffer with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module if1_fetch_buf
    import if1_pkg::*;
#(
    parameter int FETCH_WIDTH = 2,
    parameter int EXCP_W      = c_excp_w_def
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [32*FETCH_WIDTH-1:0] in_rdata,
    input  logic [EXCP_W-1:0]        in_exception,
    input  logic [1:0]               in_excp_flag,
    input  logic [31:0]              in_badv,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_inst,
    output logic [FETCH_WIDTH-1:0]   out_slot_valid,
    output logic [EXCP_W-1:0]        out_exception,
    output logic [1:0]               out_excp_flag,
    output logic [31:0]              out_badv
);

    logic [32*FETCH_WIDTH-1:0] w_align_inst;
    logic [FETCH_WIDTH-1:0]    w_align_valid;
    fetch_pkt_t                w_in_pkt;
    logic                      w_in_xfer;
    logic                      w_out_xfer;
    logic                      w_unused_head;

    buf_state_t r_state;
    fetch_pkt_t r_head;
    fetch_pkt_t r_skid;
    logic       r_out_valid;
    logic       r_in_ready;

    if1_align #(
        .FETCH_WIDTH (FETCH_WIDTH),
        .EXCP_W      (EXCP_W)
    ) u_align (
        .i_pc         (in_pc),
        .i_rdata      (in_rdata),
        .i_exception  (in_exception),
        .i_excp_flag  (in_excp_flag),
        .o_inst       (w_align_inst),
        .o_slot_valid (w_align_valid)
    );

    always_comb begin
        w_in_pkt                             = '0;
        w_in_pkt.pc                          = in_pc;
        w_in_pkt.inst[32*FETCH_WIDTH-1:0]    = w_align_inst;
        w_in_pkt.slot_valid[FETCH_WIDTH-1:0] = w_align_valid;
        w_in_pkt.exception[EXCP_W-1:0]       = in_exception;
        w_in_pkt.excp_flag                   = in_excp_flag;
        w_in_pkt.badv                        = in_badv;
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;

    // Handshake flags are registered next to the state so neither port sees a
    // combinational path from the other side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_head      <= '0;
            r_skid      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_head      <= w_in_pkt;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && !w_out_xfer) begin
                        r_skid     <= w_in_pkt;
                        r_state    <= ST_TWO;
                        r_in_ready <= 1'b0;
                    end else if (w_in_xfer && w_out_xfer) begin
                        r_head <= w_in_pkt;
                    end else if (w_out_xfer) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_head     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready       = r_in_ready;
    assign out_valid      = r_out_valid;
    assign out_pc         = r_head.pc;
    assign out_inst       = r_head.inst[32*FETCH_WIDTH-1:0];
    assign out_slot_valid = r_head.slot_valid[FETCH_WIDTH-1:0];
    assign out_exception  = r_head.exception[EXCP_W-1:0];
    assign out_excp_flag  = r_head.excp_flag;
    assign out_badv       = r_head.badv;

    assign w_unused_head = ^{r_head.inst, r_head.slot_valid, r_head.exception};

endmodule
`default_nettype wire

// File: tb/tb_if1_fetch_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_if1_fetch_buf
// Description : Bench for if1_fetch_buf at FETCH_WIDTH 2 and 4 against a
//               queue-based packet model plus directed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if1_fetch_buf;

    localparam logic [31:0] NOP = 32'h0340_0000;

    typedef struct {
        logic [31:0]  pc;
        logic [127:0] rdata;
        logic [6:0]   exc;
        logic [1:0]   flag;
        logic [31:0]  badv;
    } raw_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         out_ready;
    logic [31:0]  in_pc;
    logic [127:0] in_rdata;
    logic [6:0]   in_exception;
    logic [1:0]   in_excp_flag;
    logic [31:0]  in_badv;

    logic         ir2, ov2, ir4, ov4;
    logic [31:0]  pc2, pc4, bv2, bv4;
    logic [63:0]  inst2;
    logic [127:0] inst4;
    logic [1:0]   sv2, fl2, fl4;
    logic [3:0]   sv4;
    logic [6:0]   exc2, exc4;

    int checks   = 0;
    int failures = 0;

    raw_t         mq[$];
    logic [31:0]  log_q[$];
    bit           m_in_acc, m_out_acc, exp_valid;
    logic [127:0] e_inst;
    logic [3:0]   e_sv;

    always #5 clk = ~clk;

    if1_fetch_buf #(.FETCH_WIDTH(2), .EXCP_W(7)) u_dut2 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir2), .in_pc(in_pc), .in_rdata(in_rdata[63:0]),
        .in_exception(in_exception), .in_excp_flag(in_excp_flag), .in_badv(in_badv),
        .out_valid(ov2), .out_ready(out_ready), .out_pc(pc2), .out_inst(inst2),
        .out_slot_valid(sv2), .out_exception(exc2), .out_excp_flag(fl2), .out_badv(bv2)
    );

    if1_fetch_buf #(.FETCH_WIDTH(4), .EXCP_W(7)) u_dut4 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(ir4), .in_pc(in_pc), .in_rdata(in_rdata),
        .in_exception(in_exception), .in_excp_flag(in_excp_flag), .in_badv(in_badv),
        .out_valid(ov4), .out_ready(out_ready), .out_pc(pc4), .out_inst(inst4),
        .out_slot_valid(sv4), .out_exception(exc4), .out_excp_flag(fl4), .out_badv(bv4)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected packet from the alignment rules: offset is the PC word index
    // within the line.
    function automatic void expect_pkt(input int fw, input raw_t r,
                                       output logic [127:0] inst, output logic [3:0] sv);
        int off  = int'((r.pc / 4) % fw);
        bit excp = (r.exc != 0) || (r.flag != 0);
        inst = '0;
        sv   = '0;
        for (int i = 0; i < fw; i++) begin
            if (excp) begin
                sv[i]            = (i == off);
                inst[32*i +: 32] = NOP;
            end else if (i >= off) begin
                sv[i]            = 1'b1;
                inst[32*i +: 32] = r.rdata[32*i +: 32];
            end else begin
                inst[32*i +: 32] = NOP;
            end
        end
    endfunction

    function automatic raw_t mk(input logic [31:0] pc, input logic [127:0] rd,
                                input logic [6:0] exc, input logic [1:0] flag,
                                input logic [31:0] badv);
        raw_t r;
        r.pc = pc; r.rdata = rd; r.exc = exc; r.flag = flag; r.badv = badv;
        return r;
    endfunction

    // Model: FIFO of accepted packets, capacity two, cleared by flush/reset.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else begin
            if (ov2 && out_ready) log_q.push_back(pc2);
            m_in_acc  = in_valid && (mq.size() < 2);
            m_out_acc = (mq.size() != 0) && out_ready;
            if (flush) begin
                mq.delete();
            end else begin
                if (m_out_acc) void'(mq.pop_front());
                if (m_in_acc) mq.push_back(mk(in_pc, in_rdata, in_exception, in_excp_flag, in_badv));
            end
        end
    end

    always @(negedge clk) begin
        exp_valid = (mq.size() != 0);
        chk("out_valid_w2", ov2, exp_valid);
        chk("out_valid_w4", ov4, exp_valid);
        chk("in_ready_w2", ir2, mq.size() < 2);
        chk("in_ready_w4", ir4, mq.size() < 2);
        if (exp_valid) begin
            expect_pkt(2, mq[0], e_inst, e_sv);
            chk("pc_w2", pc2, mq[0].pc);
            chk("inst_w2", inst2, e_inst[63:0]);
            chk("slot_valid_w2", sv2, e_sv[1:0]);
            chk("exc_w2", exc2, mq[0].exc);
            chk("flag_w2", fl2, mq[0].flag);
            chk("badv_w2", bv2, mq[0].badv);
            expect_pkt(4, mq[0], e_inst, e_sv);
            chk("pc_w4", pc4, mq[0].pc);
            chk("inst_w4", inst4, e_inst);
            chk("slot_valid_w4", sv4, e_sv);
            chk("exc_w4", exc4, mq[0].exc);
            chk("flag_w4", fl4, mq[0].flag);
            chk("badv_w4", bv4, mq[0].badv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input raw_t r);
        in_valid     = 1'b1;
        in_pc        = r.pc;
        in_rdata     = r.rdata;
        in_exception = r.exc;
        in_excp_flag = r.flag;
        in_badv      = r.badv;
    endtask

    task automatic send(input raw_t r, input int budget);
        bit done;
        done = 1'b0;
        apply(r);
        for (int k = 0; k < budget && !done; k++) begin
            done = ir2;
            tick();
        end
        chk("send_accepted", done, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, {ov2, ov4}, 2'b00);
        chk({tag, "_in_ready"}, {ir2, ir4}, 2'b11);
        chk({tag, "_pc"}, {pc2, pc4}, 64'h0);
        chk({tag, "_inst"}, {inst2, inst4}, '0);
        chk({tag, "_slot_valid"}, {sv2, sv4}, 6'h0);
        chk({tag, "_exc_flag_badv"}, {exc2, exc4, fl2, fl4, bv2, bv4}, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [127:0] RD = {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hAAAA_AAAA, 32'hBBBB_BBBB};

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_rdata = '0; in_exception = '0; in_excp_flag = '0; in_badv = '0;
        #12;
        chk_reset_outputs("reset");
        tick();
        rst = 1'b0;

        // Alignment, offset 1, one-cycle latency
        out_ready = 1'b1;
        send(mk(32'h1c00_0004, RD, 7'h0, 2'h0, 32'h0), 1);
        chk("lat_out_valid", ov2, 1'b1);
        chk("a1_slot_valid_w2", sv2, 2'b10);
        chk("a1_inst_w2", inst2, {32'hAAAA_AAAA, NOP});
        chk("a1_slot_valid_w4", sv4, 4'b1110);
        chk("a1_inst_w4", inst4, {32'hDDDD_DDDD, 32'hCCCC_CCCC, 32'hAAAA_AAAA, NOP});

        // Offset 2 in the 4-wide line, offset 0 in the 2-wide line
        send(mk(32'h1c00_0008, RD, 7'h0, 2'h0, 32'h0), 1);
        chk("a2_slot_valid_w4", sv4, 4'b1100);
        chk("a2_inst_w4", inst4, {32'hDDDD_DDDD, 32'hCCCC_CCCC, NOP, NOP});
        chk("a2_slot_valid_w2", sv2, 2'b11);

        // Exception packet
        send(mk(32'h1c00_0004, RD, 7'h08, 2'h0, 32'hDEAD_BEEF), 1);
        chk("ex_slot_valid_w4", sv4, 4'b0010);
        chk("ex_inst_w4", inst4, {NOP, NOP, NOP, NOP});
        chk("ex_badv_w4", bv4, 32'hDEAD_BEEF);
        chk("ex_code_w4", exc4, 7'h08);
        chk("ex_slot_valid_w2", sv2, 2'b10);

        // Exception via flag only, offset 3
        send(mk(32'h1c00_000c, RD, 7'h0, 2'h2, 32'h1c00_000c), 1);
        chk("fl_slot_valid_w4", sv4, 4'b1000);
        chk("fl_flag_w4", fl4, 2'h2);
        tick();
        tick();

        // Back-pressure: P0, P1 fill the buffer, P2 waits upstream
        out_ready = 1'b0;
        log_q.delete();
        send(mk(32'h1c00_0100, RD, 7'h0, 2'h0, 32'h0), 1);
        send(mk(32'h1c00_0104, ~RD, 7'h0, 2'h0, 32'h0), 1);
        chk("bp_in_ready_low", {ir2, ir4}, 2'b00);
        apply(mk(32'h1c00_0108, {4{32'h1234_5678}}, 7'h0, 2'h0, 32'h0));
        tick();
        tick();
        chk("bp_head_held", pc2, 32'h1c00_0100);
        chk("bp_still_full", ir2, 1'b0);
        out_ready = 1'b1;
        send(mk(32'h1c00_0108, {4{32'h1234_5678}}, 7'h0, 2'h0, 32'h0), 4);
        tick();
        tick();
        chk("bp_out_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("bp_order0", log_q[0], 32'h1c00_0100);
            chk("bp_order1", log_q[1], 32'h1c00_0104);
            chk("bp_order2", log_q[2], 32'h1c00_0108);
        end

        // Flush while full, with a packet offered in the same cycle
        out_ready = 1'b0;
        log_q.delete();
        send(mk(32'h1c00_0200, RD, 7'h0, 2'h0, 32'h0), 1);
        send(mk(32'h1c00_0204, RD, 7'h0, 2'h0, 32'h0), 1);
        apply(mk(32'h1c00_0208, RD, 7'h0, 2'h0, 32'h0));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {ov2, ov4}, 2'b00);
        chk("fl_in_ready", {ir2, ir4}, 2'b11);
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        chk("fl_nothing_emitted", log_q.size(), 0);

        // Full throughput with out_ready held high
        for (int i = 0; i < 6; i++) begin
            send(mk(32'h1c00_0300 + 32'(4 * i),
                    {$urandom, $urandom, $urandom, $urandom},
                    (i == 3) ? 7'h05 : 7'h0, 2'h0, 32'h1c00_0300 + 32'(i)), 1);
        end
        tick();
        tick();

        // Asynchronous reset between edges while a packet is held
        out_ready = 1'b0;
        send(mk(32'h1c00_0400, RD, 7'h0, 2'h0, 32'h55AA_55AA), 1);
        chk("ar_loaded", ov2, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        rst = 1'b0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
